conv_loader: RTL and testbench
==============================

CONV_LOADER -- requirements
Module: conv_loader

Interface
REQ-001 Parameter DATA_WIDTH, default 64: width of stream data and mem_di.
REQ-002 Parameter B_LAYERPARA, default 80: width of layer parameter word.
REQ-003 Parameter B_CNT, default 16: width of word counts.
REQ-004 clk  input  1  clock; all logic on rising edge.
REQ-005 rstn  input  1  reset, synchronous, active-low.
REQ-006 cmd_valid  input  1  load command offered.
REQ-007 cmd_ready  output  1  loader can accept a command; high only in IDLE.
REQ-008 cmd_para  input  B_LAYERPARA  layer parameters for this load.
REQ-009 cmd_wb_words  input  B_CNT  number of weight-buffer words to forward.
REQ-010 cmd_kb_words  input  B_CNT  number of kernel-buffer words to forward.
REQ-011 s_tdata  input  DATA_WIDTH  memory read stream data.
REQ-012 s_tvalid  input  1  stream data valid.
REQ-013 s_tready  output  1  loader accepts stream data; high only in WEI or KER.
REQ-014 layer_para  output  B_LAYERPARA  registered parameter word to the conv unit.
REQ-015 layer_para_we  output  1  one-cycle write strobe for layer_para.
REQ-016 wb_clr, kb_clr  output  1 each  one-cycle buffer pointer clears.
REQ-017 wb_en, kb_en  output  1 each  mem_di valid for weight / kernel buffer.
REQ-018 mem_di  output  DATA_WIDTH  registered data word to the buffers.
REQ-019 busy  output  1  high in every state except IDLE.
REQ-020 done  output  1  one-cycle pulse when a load completes.

Function
REQ-021 FSM states IDLE, PARA, CLR, WEI, KER, DONE; all outputs driven from registers.
REQ-022 IDLE: cmd_valid & cmd_ready captures cmd_para, cmd_wb_words, cmd_kb_words -> PARA.
REQ-023 PARA (1 cycle): layer_para <= captured para, layer_para_we = 1 -> CLR.
REQ-024 CLR (1 cycle): wb_clr = 1 and kb_clr = 1 together; next WEI if wb_words != 0, else KER if kb_words != 0, else DONE.
REQ-025 WEI: each s_tvalid & s_tready beat gives mem_di <= s_tdata and wb_en = 1 in the following cycle; 1 cycle latency, no bubbles inserted.
REQ-026 WEI exits after the wb_words-th beat; next KER if kb_words != 0, else DONE.
REQ-027 s_tready deasserts in the same cycle the last beat of a phase is accepted, so no extra beat is consumed.
REQ-028 KER: same as WEI using kb_en and kb_words; after the last beat -> DONE.
REQ-029 DONE (1 cycle): done = 1 -> IDLE; the final wb_en/kb_en pulse coincides with the DONE cycle.
REQ-030 wb_en and kb_en never assert in the same cycle; neither asserts outside the cycle after an accepted beat.
REQ-031 s_tvalid low stalls the beat counter; the FSM holds state indefinitely.
REQ-032 Beat counter is B_CNT bits; it clears on phase entry and compares against the full count; counts up to 2^B_CNT-1 are supported without wrap.
REQ-033 mem_di holds its last value when no enable is asserted.
REQ-034 cmd_valid outside IDLE is ignored and the command is not captured.

Reset
REQ-035 rstn low at any clock edge forces IDLE, counters 0, layer_para 0, mem_di 0, and all strobes, busy, done, and s_tready 0; cmd_ready is 1 from the first cycle after reset.
REQ-036 Reset mid-load abandons the load; no done pulse is issued and no further strobes are driven.

Structure
REQ-037 State encoding and default widths (DATA_WIDTH, B_LAYERPARA, B_CNT) live in the shared conv package, also used by conv_unit.
REQ-038 Single flat module; one sub-module, beat_counter (load, enable, terminal-count flag), is permitted.

Verification
REQ-039 cmd para=0x1234, wb=3, kb=2, s_tvalid held high -> layer_para_we at cycle 1, clears at cycle 2, wb_en on 3 consecutive cycles, kb_en on 2 consecutive cycles, done 1 cycle after CLR+5 beats, exactly 5 beats consumed.
REQ-040 wb=0, kb=0 -> PARA, CLR, DONE on consecutive cycles; s_tready never high; no enables asserted.
REQ-041 wb=4, kb=0, s_tvalid toggling 1,0,1,0 -> 4 wb_en pulses each one cycle after an accepted beat; mem_di equals the sent words in order.
REQ-042 rstn low during the 2nd kernel beat of wb=2, kb=4 -> next cycle IDLE, all outputs 0, cmd_ready 1, no done.
REQ-043 cmd_valid held high through a load -> exactly one capture per IDLE visit; a second load starts only after done.
REQ-044 wb=65535, kb=1 -> 65535 wb_en pulses then 1 kb_en pulse; no counter wrap.

Source files
------------

// File: rtl/conv_loader_pkg.sv
// Shared conv package: loader state encoding and default datapath widths,
// also imported by conv_unit.
package conv_loader_pkg;

  localparam int DATA_WIDTH_DEF  = 64;
  localparam int B_LAYERPARA_DEF = 80;
  localparam int B_CNT_DEF       = 16;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PARA = 3'd1,
    ST_CLR  = 3'd2,
    ST_WEI  = 3'd3,
    ST_KER  = 3'd4,
    ST_DONE = 3'd5
  } loader_state_e;

endpackage

// File: rtl/conv_loader_beat_counter.sv
// Beat counter for one load phase: clear, count enable, and a terminal flag
// raised on the beat that reaches the target count.
module conv_loader_beat_counter #(
  parameter int B_CNT = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [B_CNT-1:0] i_target,
  output logic             o_last
);

  logic [B_CNT-1:0] r_count;
  logic [B_CNT:0]   w_next;

  // One extra bit so a target of 2^B_CNT-1 is reached without wrapping.
  assign w_next = {1'b0, r_count} + {{B_CNT{1'b0}}, 1'b1};
  assign o_last = i_en & (w_next == {1'b0, i_target});

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= w_next[B_CNT-1:0];
    end
  end

endmodule

// File: rtl/conv_loader.sv
// Conv layer loader: captures a load command, writes the layer parameter word,
// clears both buffers, then forwards weight and kernel words from the stream.
module conv_loader
  import conv_loader_pkg::*;
#(
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int B_LAYERPARA = B_LAYERPARA_DEF,
  parameter int B_CNT       = B_CNT_DEF
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [B_LAYERPARA-1:0] cmd_para,
  input  logic [B_CNT-1:0]       cmd_wb_words,
  input  logic [B_CNT-1:0]       cmd_kb_words,
  input  logic [DATA_WIDTH-1:0]  s_tdata,
  input  logic                   s_tvalid,
  output logic                   s_tready,
  output logic [B_LAYERPARA-1:0] layer_para,
  output logic                   layer_para_we,
  output logic                   wb_clr,
  output logic                   kb_clr,
  output logic                   wb_en,
  output logic                   kb_en,
  output logic [DATA_WIDTH-1:0]  mem_di,
  output logic                   busy,
  output logic                   done,
  output logic [2:0]             dbg_state
);

  loader_state_e          r_state;
  loader_state_e          w_state_nxt;
  logic [B_CNT-1:0]       r_wb_words;
  logic [B_CNT-1:0]       r_kb_words;
  logic [B_LAYERPARA-1:0] r_layer_para;
  logic [DATA_WIDTH-1:0]  r_mem_di;
  logic                   r_cmd_ready;
  logic                   r_s_tready;
  logic                   r_layer_para_we;
  logic                   r_wb_clr;
  logic                   r_kb_clr;
  logic                   r_wb_en;
  logic                   r_kb_en;
  logic                   r_busy;
  logic                   r_done;

  logic                   w_accept;
  logic                   w_beat;
  logic                   w_in_wei;
  logic                   w_in_ker;
  logic                   w_cnt_en;
  logic                   w_cnt_clr;
  logic                   w_last;
  logic [B_CNT-1:0]       w_target;

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; ready never depends combinationally on valid, and valid may
  // rise or fall at any time without penalty.
  assign w_accept  = cmd_valid & r_cmd_ready;
  assign w_beat    = s_tvalid & r_s_tready;
  assign w_in_wei  = (r_state == ST_WEI);
  assign w_in_ker  = (r_state == ST_KER);
  assign w_cnt_en  = w_beat & (w_in_wei | w_in_ker);
  assign w_cnt_clr = (r_state == ST_CLR) | (w_in_wei & w_last);
  assign w_target  = w_in_ker ? r_kb_words : r_wb_words;

  conv_loader_beat_counter #(
    .B_CNT (B_CNT)
  ) u_beat_counter (
    .clk      (clk),
    .rstn     (rstn),
    .i_clr    (w_cnt_clr),
    .i_en     (w_cnt_en),
    .i_target (w_target),
    .o_last   (w_last)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_state_nxt = ST_PARA;
      ST_PARA: w_state_nxt = ST_CLR;
      ST_CLR: begin
        if (r_wb_words != '0)      w_state_nxt = ST_WEI;
        else if (r_kb_words != '0) w_state_nxt = ST_KER;
        else                       w_state_nxt = ST_DONE;
      end
      ST_WEI: if (w_last) w_state_nxt = (r_kb_words != '0) ? ST_KER : ST_DONE;
      ST_KER: if (w_last) w_state_nxt = ST_DONE;
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Strobes are registered from the next state so they line up with the
  // state they belong to; ready drops on the edge that takes the final beat.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state         <= ST_IDLE;
      r_wb_words      <= '0;
      r_kb_words      <= '0;
      r_layer_para    <= '0;
      r_mem_di        <= '0;
      r_cmd_ready     <= 1'b1;
      r_s_tready      <= 1'b0;
      r_layer_para_we <= 1'b0;
      r_wb_clr        <= 1'b0;
      r_kb_clr        <= 1'b0;
      r_wb_en         <= 1'b0;
      r_kb_en         <= 1'b0;
      r_busy          <= 1'b0;
      r_done          <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_cmd_ready     <= (w_state_nxt == ST_IDLE);
      r_busy          <= (w_state_nxt != ST_IDLE);
      r_s_tready      <= (w_state_nxt == ST_WEI) | (w_state_nxt == ST_KER);
      r_layer_para_we <= (w_state_nxt == ST_PARA);
      r_wb_clr        <= (w_state_nxt == ST_CLR);
      r_kb_clr        <= (w_state_nxt == ST_CLR);
      r_done          <= (w_state_nxt == ST_DONE);
      r_wb_en         <= w_beat & w_in_wei;
      r_kb_en         <= w_beat & w_in_ker;
      if (w_beat) r_mem_di <= s_tdata;
      if (w_accept) begin
        r_layer_para <= cmd_para;
        r_wb_words   <= cmd_wb_words;
        r_kb_words   <= cmd_kb_words;
      end
    end
  end

  assign cmd_ready     = r_cmd_ready;
  assign s_tready      = r_s_tready;
  assign layer_para    = r_layer_para;
  assign layer_para_we = r_layer_para_we;
  assign wb_clr        = r_wb_clr;
  assign kb_clr        = r_kb_clr;
  assign wb_en         = r_wb_en;
  assign kb_en         = r_kb_en;
  assign mem_di        = r_mem_di;
  assign busy          = r_busy;
  assign done          = r_done;
  assign dbg_state     = r_state;

endmodule

// File: tb/tb_conv_loader.sv
// Bench for conv_loader: stream feeder with a per-buffer expected-data queue,
// plus one task per scenario checking strobe timing and counts.
module tb_conv_loader;
  import conv_loader_pkg::*;

  localparam int DW = 64;
  localparam int PW = 80;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [PW-1:0] cmd_para = '0;
  logic [CW-1:0] cmd_wb_words = '0;
  logic [CW-1:0] cmd_kb_words = '0;
  logic [DW-1:0] s_tdata = '0;
  logic          s_tvalid = 1'b0;
  logic          s_tready;
  logic [PW-1:0] layer_para;
  logic          layer_para_we;
  logic          wb_clr;
  logic          kb_clr;
  logic          wb_en;
  logic          kb_en;
  logic [DW-1:0] mem_di;
  logic          busy;
  logic          done;
  logic [2:0]    dbg_state;

  conv_loader #(.DATA_WIDTH(DW), .B_LAYERPARA(PW), .B_CNT(CW)) dut (
    .clk(clk), .rstn(rstn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_para(cmd_para), .cmd_wb_words(cmd_wb_words), .cmd_kb_words(cmd_kb_words),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .layer_para(layer_para), .layer_para_we(layer_para_we),
    .wb_clr(wb_clr), .kb_clr(kb_clr), .wb_en(wb_en), .kb_en(kb_en),
    .mem_di(mem_di), .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  // Clock / reset-edge tracking
  always #5 clk = ~clk;

  logic rst_edge = 1'b1;
  initial forever begin
    @(posedge clk);
    rst_edge = !rstn;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard state
  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_wb_q[$];
  logic [DW-1:0] exp_kb_q[$];
  logic [DW-1:0] last_exp = '0;
  logic exp_wb_nx = 1'b0;
  logic exp_kb_nx = 1'b0;
  int beats_acc = 0;
  int cur_wb = 0;
  int cur_kb = 0;
  int feed_mode = 0;
  int wb_cnt = 0;
  int kb_cnt = 0;
  int done_cnt = 0;

  // Per-cycle monitor then stream driver, in that order, on every falling edge.
  initial forever begin
    @(negedge clk);
    if (rst_edge) begin
      exp_wb_q.delete();
      exp_kb_q.delete();
      last_exp = '0;
    end else begin
      checks++;
      if (wb_en !== exp_wb_nx || kb_en !== exp_kb_nx) begin
        errors++;
        $display("FAIL strobe_timing t=%0t wb_en=%b kb_en=%b expected wb_en=%b kb_en=%b",
                 $time, wb_en, kb_en, exp_wb_nx, exp_kb_nx);
      end
      if (wb_en) wb_cnt++;
      if (kb_en) kb_cnt++;
      if (done) done_cnt++;
      if (exp_wb_nx && exp_wb_q.size() > 0) last_exp = exp_wb_q.pop_front();
      else if (exp_kb_nx && exp_kb_q.size() > 0) last_exp = exp_kb_q.pop_front();
      checks++;
      if (mem_di !== last_exp) begin
        errors++;
        $display("FAIL mem_di t=%0t got %h expected %h", $time, mem_di, last_exp);
      end
    end
    case (feed_mode)
      1:       s_tvalid = 1'b1;
      2:       s_tvalid = ~s_tvalid;
      3:       s_tvalid = 1'($urandom_range(0, 1));
      default: s_tvalid = 1'b0;
    endcase
    s_tdata = {$urandom(), $urandom()};
    exp_wb_nx = 1'b0;
    exp_kb_nx = 1'b0;
    if (rstn && s_tvalid && s_tready) begin
      if ((cur_wb + cur_kb) > 0 && (beats_acc % (cur_wb + cur_kb)) < cur_wb) begin
        exp_wb_q.push_back(s_tdata);
        exp_wb_nx = 1'b1;
      end else begin
        exp_kb_q.push_back(s_tdata);
        exp_kb_nx = 1'b1;
      end
      beats_acc++;
    end
  end

  // Driver tasks
  task automatic start_load(input logic [PW-1:0] para, input int wb, input int kb,
                            input bit hold);
    @(negedge clk);
    cmd_para     = para;
    cmd_wb_words = CW'(wb);
    cmd_kb_words = CW'(kb);
    cmd_valid    = 1'b1;
    cur_wb       = wb;
    cur_kb       = kb;
    beats_acc    = 0;
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL cmd_ready_idle got %b expected 1", cmd_ready);
    end
    @(negedge clk);
    if (!hold) cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc, input string name);
    int n;
    n = 0;
    while (done !== 1'b1 && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL %s_done_timeout no done within %0d cycles", name, max_cyc);
    end
  endtask

  task automatic check_counts(input string name, input int s_wb, input int s_kb,
                              input int s_done, input int e_wb, input int e_kb,
                              input int e_done, input int e_beats);
    checks++;
    if (wb_cnt - s_wb != e_wb || kb_cnt - s_kb != e_kb || done_cnt - s_done != e_done ||
        beats_acc != e_beats || exp_wb_q.size() != 0 || exp_kb_q.size() != 0) begin
      errors++;
      $display("FAIL %s_counts got wb=%0d kb=%0d done=%0d beats=%0d qwb=%0d qkb=%0d expected wb=%0d kb=%0d done=%0d beats=%0d q=0",
               name, wb_cnt - s_wb, kb_cnt - s_kb, done_cnt - s_done, beats_acc,
               exp_wb_q.size(), exp_kb_q.size(), e_wb, e_kb, e_done, e_beats);
    end
  endtask

  // Scenarios
  task automatic test_reset();
    rstn = 1'b0;
    feed_mode = 0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, s_tready, layer_para_we, wb_clr, kb_clr, wb_en, kb_en} !== 8'h00 ||
        layer_para !== '0 || mem_di !== '0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_outputs got strobes=%b para=%h mem_di=%h cmd_ready=%b expected 0/0/0/1",
               {busy, done, s_tready, layer_para_we, wb_clr, kb_clr, wb_en, kb_en},
               layer_para, mem_di, cmd_ready);
    end
    rstn = 1'b1;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0 || dbg_state !== ST_IDLE) begin
      errors++;
      $display("FAIL reset_release got cmd_ready=%b busy=%b state=%0d expected 1 0 0",
               cmd_ready, busy, dbg_state);
    end
  endtask

  task automatic test_basic();
    int s_wb, s_kb, s_done;
    logic e_wb, e_kb, e_done, e_rdy;
    s_wb = wb_cnt; s_kb = kb_cnt; s_done = done_cnt;
    feed_mode = 1;
    start_load(80'h1234, 3, 2, 1'b0);
    checks++;
    if (layer_para_we !== 1'b1 || layer_para !== 80'h1234 || busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_para got we=%b para=%h busy=%b expected 1 1234 1",
               layer_para_we, layer_para, busy);
    end
    @(negedge clk);
    checks++;
    if ({layer_para_we, wb_clr, kb_clr} !== 3'b011) begin
      errors++;
      $display("FAIL basic_clr got we/wb_clr/kb_clr=%b expected 011",
               {layer_para_we, wb_clr, kb_clr});
    end
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      e_wb   = (k >= 2 && k <= 4);
      e_kb   = (k >= 5);
      e_done = (k == 6);
      e_rdy  = (k <= 5);
      checks++;
      if ({wb_en, kb_en, done, s_tready} !== {e_wb, e_kb, e_done, e_rdy}) begin
        errors++;
        $display("FAIL basic_cycle%0d got wb/kb/done/rdy=%b expected %b", k,
                 {wb_en, kb_en, done, s_tready}, {e_wb, e_kb, e_done, e_rdy});
      end
    end
    @(negedge clk);
    feed_mode = 0;
    check_counts("basic", s_wb, s_kb, s_done, 3, 2, 1, 5);
  endtask

  task automatic test_zero();
    int s_wb, s_kb, s_done;
    s_wb = wb_cnt; s_kb = kb_cnt; s_done = done_cnt;
    feed_mode = 1;
    start_load(80'hA5, 0, 0, 1'b0);
    checks++;
    if ({layer_para_we, s_tready} !== 2'b10) begin
      errors++;
      $display("FAIL zero_para got we/rdy=%b expected 10", {layer_para_we, s_tready});
    end
    @(negedge clk);
    checks++;
    if ({wb_clr, kb_clr, s_tready} !== 3'b110) begin
      errors++;
      $display("FAIL zero_clr got clr/rdy=%b expected 110", {wb_clr, kb_clr, s_tready});
    end
    @(negedge clk);
    checks++;
    if ({done, busy, s_tready} !== 3'b110) begin
      errors++;
      $display("FAIL zero_done got done/busy/rdy=%b expected 110", {done, busy, s_tready});
    end
    @(negedge clk);
    checks++;
    if ({cmd_ready, busy, done} !== 3'b100) begin
      errors++;
      $display("FAIL zero_idle got ready/busy/done=%b expected 100", {cmd_ready, busy, done});
    end
    feed_mode = 0;
    check_counts("zero", s_wb, s_kb, s_done, 0, 0, 1, 0);
  endtask

  task automatic test_stream(input string name, input int mode, input int wb, input int kb,
                             input int max_cyc);
    int s_wb, s_kb, s_done;
    s_wb = wb_cnt; s_kb = kb_cnt; s_done = done_cnt;
    s_tvalid = 1'b0;
    feed_mode = mode;
    start_load(PW'($urandom()), wb, kb, 1'b0);
    wait_done(max_cyc, name);
    @(negedge clk);
    feed_mode = 0;
    check_counts(name, s_wb, s_kb, s_done, wb, kb, 1, wb + kb);
  endtask

  task automatic test_hold_cmd();
    int s_done, d_off, w_off;
    s_done = done_cnt;
    d_off = -1;
    w_off = -1;
    feed_mode = 1;
    start_load(80'hAAAA, 1, 1, 1'b1);
    cmd_para = 80'hBBBB;
    @(negedge clk);
    checks++;
    if (layer_para !== 80'hAAAA || cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL hold_ignore got para=%h cmd_ready=%b expected aaaa 0", layer_para, cmd_ready);
    end
    for (int off = 2; off <= 12; off++) begin
      @(negedge clk);
      if (done === 1'b1 && d_off < 0) d_off = off;
      if (layer_para_we === 1'b1) begin
        w_off = off;
        break;
      end
    end
    checks++;
    if (d_off != 4 || w_off != 6 || layer_para !== 80'hBBBB) begin
      errors++;
      $display("FAIL hold_recapture got done_off=%0d we_off=%0d para=%h expected 4 6 bbbb",
               d_off, w_off, layer_para);
    end
    cmd_valid = 1'b0;
    wait_done(20, "hold");
    w_off = 0;
    repeat (4) begin
      @(negedge clk);
      if (layer_para_we === 1'b1) w_off++;
    end
    feed_mode = 0;
    checks++;
    if (w_off != 0 || cmd_ready !== 1'b1 || done_cnt - s_done != 2) begin
      errors++;
      $display("FAIL hold_end got extra_we=%0d cmd_ready=%b dones=%0d expected 0 1 2",
               w_off, cmd_ready, done_cnt - s_done);
    end
  endtask

  task automatic test_reset_mid();
    int s_wb, s_kb, s_done;
    s_wb = wb_cnt; s_kb = kb_cnt; s_done = done_cnt;
    feed_mode = 1;
    start_load(80'h77, 2, 4, 1'b0);
    @(negedge clk);
    repeat (4) @(posedge clk);
    #2;
    rstn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy, done, s_tready, layer_para_we, wb_clr, kb_clr, wb_en, kb_en} !== 8'h00 ||
        layer_para !== '0 || mem_di !== '0 || cmd_ready !== 1'b1 || dbg_state !== ST_IDLE) begin
      errors++;
      $display("FAIL midreset_outputs got strobes=%b para=%h mem_di=%h ready=%b state=%0d expected 0/0/0/1/0",
               {busy, done, s_tready, layer_para_we, wb_clr, kb_clr, wb_en, kb_en},
               layer_para, mem_di, cmd_ready, dbg_state);
    end
    rstn = 1'b1;
    repeat (5) @(negedge clk);
    feed_mode = 0;
    check_counts("midreset", s_wb, s_kb, s_done, 2, 1, 0, 3);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero();
    test_stream("toggle", 2, 4, 0, 40);
    test_stream("random", 3, 5, 3, 200);
    test_hold_cmd();
    test_reset_mid();
    test_stream("long", 1, 65535, 1, 70000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
